// File: rtl/gcd_scheduler_if.sv
// gcd_scheduler_if: requester handshake and shared GCD-unit signals of the scheduler
interface gcd_scheduler_if #(
    parameter int N_REQ = 4,
    parameter int W     = 32
);
    logic [N_REQ-1:0]   req;
    logic [N_REQ*W-1:0] a_req;
    logic [N_REQ*W-1:0] b_req;
    logic [N_REQ-1:0]   gnt;
    logic [N_REQ-1:0]   rsp_valid;
    logic [W-1:0]       rsp_data;
    logic               rsp_err;
    logic               busy;
    logic               gcd_start;
    logic [W-1:0]       gcd_a;
    logic [W-1:0]       gcd_b;
    logic               gcd_ready;
    logic               gcd_done;
    logic [W-1:0]       gcd_result;

    modport master (
        output req, a_req, b_req, gcd_ready, gcd_done, gcd_result,
        input  gnt, rsp_valid, rsp_data, rsp_err, busy, gcd_start, gcd_a, gcd_b
    );

    modport slave (
        input  req, a_req, b_req, gcd_ready, gcd_done, gcd_result,
        output gnt, rsp_valid, rsp_data, rsp_err, busy, gcd_start, gcd_a, gcd_b
    );
endinterface

// File: rtl/gcd_scheduler.sv
// gcd_scheduler: round-robin sharing of one GCD unit among N_REQ requesters with timeout
module gcd_scheduler #(
    parameter int N_REQ   = 4,
    parameter int W       = 32,
    parameter int TIMEOUT = 1024
) (
    input logic            clk,
    input logic            reset,
    gcd_scheduler_if.slave bus
);
    localparam int IW = $clog2(N_REQ);
    localparam int CW = $clog2(TIMEOUT + 1);

    typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESPOND} state_t;

    state_t           state, state_nxt;
    logic [IW-1:0]    ptr, idx, win;
    logic             found;
    logic [W-1:0]     a_lat, b_lat, res;
    logic             err;
    logic [CW-1:0]    cnt;
    logic             both_zero, expired;
    logic [N_REQ-1:0] idx_oh;

    assign both_zero = a_lat == '0 && b_lat == '0;
    assign expired   = cnt == CW'(TIMEOUT - 1);
    assign idx_oh    = N_REQ'(1) << idx;

    // round-robin pick: first requesting index after the last served one
    always_comb begin
        found = 1'b0;
        win   = '0;
        for (int k = 1; k <= N_REQ; k++) begin
            if (!found && bus.req[(int'(ptr) + k) % N_REQ]) begin
                found = 1'b1;
                win   = IW'((int'(ptr) + k) % N_REQ);
            end
        end
    end

    // state register
    always_ff @(posedge clk or posedge reset) begin
        if (reset) state <= IDLE;
        else       state <= state_nxt;
    end

    // next state and Moore outputs; everything is zero while idle
    always_comb begin
        state_nxt     = state;
        bus.gnt       = '0;
        bus.rsp_valid = '0;
        bus.rsp_data  = '0;
        bus.rsp_err   = 1'b0;
        bus.busy      = state != IDLE;
        bus.gcd_start = 1'b0;
        bus.gcd_a     = '0;
        bus.gcd_b     = '0;
        case (state)
            IDLE: if (found && bus.gcd_ready) state_nxt = ISSUE;
            ISSUE: begin
                bus.gnt       = idx_oh;
                bus.gcd_start = !both_zero;
                bus.gcd_a     = a_lat;
                bus.gcd_b     = b_lat;
                state_nxt     = both_zero ? RESPOND : WAIT;
            end
            WAIT: begin
                bus.gcd_a = a_lat;
                bus.gcd_b = b_lat;
                if (bus.gcd_done || expired) state_nxt = RESPOND;
            end
            RESPOND: begin
                bus.rsp_valid = idx_oh;
                bus.rsp_data  = res;
                bus.rsp_err   = err;
                state_nxt     = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    // operand latch, result capture, wait counter and last-served pointer
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            ptr   <= IW'(N_REQ - 1);
            idx   <= '0;
            a_lat <= '0;
            b_lat <= '0;
            res   <= '0;
            err   <= 1'b0;
            cnt   <= '0;
        end else begin
            case (state)
                IDLE: if (found && bus.gcd_ready) begin
                    idx   <= win;
                    a_lat <= bus.a_req[int'(win)*W +: W];
                    b_lat <= bus.b_req[int'(win)*W +: W];
                end
                ISSUE: begin
                    cnt <= '0;
                    res <= '0;
                    err <= both_zero;
                end
                WAIT: begin
                    if (bus.gcd_done) begin
                        res <= bus.gcd_result;
                        err <= 1'b0;
                    end else if (expired) begin
                        res <= '0;
                        err <= 1'b1;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                RESPOND: ptr <= idx;
                default: ;
            endcase
        end
    end
endmodule
